// File: rtl/ddr_cmd_arbiter.sv
// Two-requester (write capture / read readback) arbiter feeding a DDR command port.
// Optional grant statistics counters are built when ARB_STATS_EN is defined.
module ddr_cmd_arbiter #(
    parameter int unsigned BL         = 63,
    parameter int unsigned WR_STREAK  = 4,
    parameter int unsigned RD_MAX_OUT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_req,
    input  logic [29:0] wr_addr,
    input  logic [6:0]  wr_fill,
    output logic        wr_gnt,
    input  logic        rd_req,
    input  logic [29:0] rd_addr,
    output logic        rd_gnt,
    input  logic        rd_burst_done,
    input  logic        cmd_full,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [29:0] cmd_addr,
    output logic [5:0]  cmd_bl,
    output logic        busy,
    output logic [15:0] stat_wr_cnt,
    output logic [15:0] stat_rd_cnt
);

    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned FILL_W   = 7;
    localparam int unsigned BL_W     = 6;
    localparam int unsigned STREAK_W = $clog2(WR_STREAK + 1);
    localparam int unsigned RD_OUT_W = $clog2(RD_MAX_OUT + 1);

    localparam logic [FILL_W-1:0]   WR_THRESH  = FILL_W'(BL + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(WR_STREAK);
    localparam logic [RD_OUT_W-1:0] RD_LIMIT   = RD_OUT_W'(RD_MAX_OUT);
    localparam logic [2:0]          INSTR_WR   = 3'b000;
    localparam logic [2:0]          INSTR_RD   = 3'b001;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                win_wr_q, win_wr_d;
    logic [2:0]          instr_q, instr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BL_W-1:0]     bl_q, bl_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [RD_OUT_W-1:0] rd_out_q, rd_out_d;

    logic wr_elig_c;
    logic rd_elig_c;
    logic pick_wr_c;
    logic issue_c;
    logic wr_gnt_c;
    logic rd_gnt_c;
    logic [ADDR_W-1:0] sel_addr_c;

    assign wr_elig_c = wr_req && (wr_fill >= WR_THRESH);
    assign rd_elig_c = rd_req && (rd_out_q < RD_LIMIT);

    // Write wins ties until it has starved a pending read for WR_STREAK grants.
    assign pick_wr_c  = wr_elig_c && (!rd_elig_c || (streak_q < STREAK_MAX));
    assign sel_addr_c = pick_wr_c ? wr_addr : rd_addr;

    // Issue is gated by reset so an in-flight command is dropped cleanly.
    assign issue_c  = (state_q == ST_ISSUE) && !cmd_full && !reset;
    assign wr_gnt_c = issue_c && win_wr_q;
    assign rd_gnt_c = issue_c && !win_wr_q;

    // Next-state and command latch.
    always_comb begin
        state_d  = state_q;
        win_wr_d = win_wr_q;
        instr_d  = instr_q;
        addr_d   = addr_q;
        bl_d     = bl_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_elig_c || rd_elig_c) begin
                    win_wr_d = pick_wr_c;
                    instr_d  = pick_wr_c ? INSTR_WR : INSTR_RD;
                    addr_d   = sel_addr_c & ~ADDR_W'(3);
                    bl_d     = BL_W'(BL);
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!cmd_full) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write-streak and outstanding-read bookkeeping.
    always_comb begin
        streak_d = streak_q;
        rd_out_d = rd_out_q;
        if (wr_gnt_c) begin
            if (rd_req) begin
                streak_d = (streak_q >= STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
            end else begin
                streak_d = '0;
            end
        end else if (rd_gnt_c) begin
            streak_d = '0;
        end

        if (rd_gnt_c && !(rd_burst_done && (rd_out_q != '0))) begin
            rd_out_d = rd_out_q + RD_OUT_W'(1);
        end else if (!rd_gnt_c && rd_burst_done && (rd_out_q != '0)) begin
            rd_out_d = rd_out_q - RD_OUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            win_wr_q <= 1'b0;
            instr_q  <= '0;
            addr_q   <= '0;
            bl_q     <= '0;
            streak_q <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            win_wr_q <= win_wr_d;
            instr_q  <= instr_d;
            addr_q   <= addr_d;
            bl_q     <= bl_d;
            streak_q <= streak_d;
            rd_out_q <= rd_out_d;
        end
    end

    assign cmd_en    = issue_c;
    assign wr_gnt    = wr_gnt_c;
    assign rd_gnt    = rd_gnt_c;
    assign cmd_instr = instr_q;
    assign cmd_addr  = addr_q;
    assign cmd_bl    = bl_q;
    assign busy      = (state_q != ST_IDLE) || (rd_out_q != '0);

`ifdef ARB_STATS_EN
    logic [15:0] stat_wr_q;
    logic [15:0] stat_rd_q;

    // Saturating grant counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else begin
            if (wr_gnt_c && (stat_wr_q != 16'hFFFF)) begin
                stat_wr_q <= stat_wr_q + 16'd1;
            end
            if (rd_gnt_c && (stat_rd_q != 16'hFFFF)) begin
                stat_rd_q <= stat_rd_q + 16'd1;
            end
        end
    end

    assign stat_wr_cnt = stat_wr_q;
    assign stat_rd_cnt = stat_rd_q;
`else
    assign stat_wr_cnt = '0;
    assign stat_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Directed self-checking bench for ddr_cmd_arbiter (inputs driven 1 time unit
// after posedge, outputs sampled on negedge).
module tb_ddr_cmd_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req;
    logic [29:0] wr_addr;
    logic [6:0]  wr_fill;
    logic        wr_gnt;
    logic        rd_req;
    logic [29:0] rd_addr;
    logic        rd_gnt;
    logic        rd_burst_done;
    logic        cmd_full;
    logic        cmd_en;
    logic [2:0]  cmd_instr;
    logic [29:0] cmd_addr;
    logic [5:0]  cmd_bl;
    logic        busy;
    logic [15:0] stat_wr_cnt;
    logic [15:0] stat_rd_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ddr_cmd_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_fill      (wr_fill),
        .wr_gnt       (wr_gnt),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_gnt       (rd_gnt),
        .rd_burst_done(rd_burst_done),
        .cmd_full     (cmd_full),
        .cmd_en       (cmd_en),
        .cmd_instr    (cmd_instr),
        .cmd_addr     (cmd_addr),
        .cmd_bl       (cmd_bl),
        .busy         (busy),
        .stat_wr_cnt  (stat_wr_cnt),
        .stat_rd_cnt  (stat_rd_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Retire any outstanding reads; extra pulses also exercise the no-underflow rule.
    task automatic drain();
        step();
        wr_req = 1'b0;
        rd_req = 1'b0;
        rd_burst_done = 1'b1;
        step();
        step();
        step();
        rd_burst_done = 1'b0;
        sample();
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_write(input logic [29:0] a);
        logic got;
        got = 1'b0;
        step();
        wr_req  = 1'b1;
        wr_fill = 7'd64;
        wr_addr = a;
        for (int i = 0; i < 6 && !got; i++) begin
            step();
            sample();
            if (wr_gnt) got = 1'b1;
        end
        step();
        wr_req = 1'b0;
        check("write_granted", 32'(got), 32'd1);
    endtask

    logic exp_seq [10];
    int   g;
    int   cnt;
    logic prev_rd;
    logic en_seen;

    initial begin
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        reset = 1'b1;
        wr_req = 1'b0; wr_addr = '0; wr_fill = '0;
        rd_req = 1'b0; rd_addr = '0; rd_burst_done = 1'b0; cmd_full = 1'b0;

        // Reset state
        step(); step(); step();
        reset = 1'b0;
        sample();
        check("rst_cmd_en", 32'(cmd_en), 32'd0);
        check("rst_wr_gnt", 32'(wr_gnt), 32'd0);
        check("rst_rd_gnt", 32'(rd_gnt), 32'd0);
        check("rst_addr", 32'(cmd_addr), 32'd0);
        check("rst_bl", 32'(cmd_bl), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stat_wr", 32'(stat_wr_cnt), 32'd0);
        check("rst_stat_rd", 32'(stat_rd_cnt), 32'd0);

        // Single write, one-cycle latency, address alignment
        step();
        wr_req = 1'b1; wr_fill = 7'd64; wr_addr = 30'h103;
        sample();
        check("w1_pre_en", 32'(cmd_en), 32'd0);
        step();
        sample();
        check("w1_en", 32'(cmd_en), 32'd1);
        check("w1_instr", 32'(cmd_instr), 32'd0);
        check("w1_addr", 32'(cmd_addr), 32'h100);
        check("w1_bl", 32'(cmd_bl), 32'd63);
        check("w1_wr_gnt", 32'(wr_gnt), 32'd1);
        check("w1_rd_gnt", 32'(rd_gnt), 32'd0);
        step();
        wr_req = 1'b0;
        sample();
        check("w1_en_off", 32'(cmd_en), 32'd0);
        check("w1_gnt_off", 32'(wr_gnt), 32'd0);
        check("w1_busy", 32'(busy), 32'd0);

        // Underfilled write must not block a read
        step();
        wr_req = 1'b1; wr_fill = 7'd63; wr_addr = 30'h300;
        rd_req = 1'b1; rd_addr = 30'h205;
        step();
        sample();
        check("uf_rd_gnt", 32'(rd_gnt), 32'd1);
        check("uf_wr_gnt", 32'(wr_gnt), 32'd0);
        check("uf_instr", 32'(cmd_instr), 32'd1);
        check("uf_addr", 32'(cmd_addr), 32'h204);
        step();
        rd_req = 1'b0;
        sample();
        check("uf_idle", 32'(cmd_en), 32'd0);
        step();
        sample();
        check("uf_wait", 32'(cmd_en), 32'd0);
        wr_fill = 7'd64;
        step();
        sample();
        check("uf_wr_gnt2", 32'(wr_gnt), 32'd1);
        check("uf_addr2", 32'(cmd_addr), 32'h300);
        step();
        wr_req = 1'b0;
        sample();
        check("uf_busy_rd_out", 32'(busy), 32'd1);
        drain();

        // Write streak fairness: W W W W R W W W W R
        step();
        wr_req = 1'b1; wr_fill = 7'd64; wr_addr = 30'h1000;
        rd_req = 1'b1; rd_addr = 30'h2000;
        g = 0;
        prev_rd = 1'b0;
        for (int i = 0; i < 40 && g < 10; i++) begin
            step();
            rd_burst_done = prev_rd;
            sample();
            prev_rd = rd_gnt;
            if (cmd_en) begin
                check($sformatf("order_%0d", g), 32'(rd_gnt), 32'(exp_seq[g]));
                g++;
            end
        end
        check("order_cnt", 32'(g), 32'd10);
        step();
        wr_req = 1'b0; rd_req = 1'b0; rd_burst_done = prev_rd;
        drain();

        // Outstanding read limit
        step();
        rd_req = 1'b1; rd_addr = 30'h40;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            sample();
            if (rd_gnt) cnt++;
        end
        check("rdmax_cnt", 32'(cnt), 32'd2);
        step();
        rd_burst_done = 1'b1;
        sample();
        cnt = 0;
        if (rd_gnt) cnt++;
        for (int i = 0; i < 10; i++) begin
            step();
            rd_burst_done = 1'b0;
            sample();
            if (rd_gnt) cnt++;
        end
        check("rdmax_third", 32'(cnt), 32'd1);
        drain();

        // Back-pressure holds the latched command frozen
        step();
        cmd_full = 1'b1;
        wr_req = 1'b1; wr_fill = 7'd64; wr_addr = 30'h0ABCDEF7;
        sample();
        en_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) begin
                wr_req  = 1'b0;
                wr_addr = 30'h11111111;
                rd_req  = 1'b1;
                rd_addr = 30'h22222222;
            end
            sample();
            if (cmd_en || wr_gnt || rd_gnt) en_seen = 1'b1;
        end
        check("full_no_en", 32'(en_seen), 32'd0);
        check("full_frozen_addr", 32'(cmd_addr), 32'h0ABCDEF4);
        step();
        cmd_full = 1'b0;
        sample();
        check("full_release_en", 32'(cmd_en), 32'd1);
        check("full_release_gnt", 32'(wr_gnt), 32'd1);
        check("full_release_addr", 32'(cmd_addr), 32'h0ABCDEF4);
        step();
        rd_req = 1'b0;
        sample();
        check("full_after", 32'(cmd_en), 32'd0);
        drain();

        // Reset during ISSUE discards the command
        step();
        wr_req = 1'b1; wr_fill = 7'd64; wr_addr = 30'h500;
        step();
        reset = 1'b1;
        wr_req = 1'b0;
        sample();
        check("rsti_en", 32'(cmd_en), 32'd0);
        check("rsti_gnt", 32'(wr_gnt), 32'd0);
        step();
        reset = 1'b0;
        sample();
        check("rsti_busy", 32'(busy), 32'd0);
        check("rsti_addr", 32'(cmd_addr), 32'd0);
        check("rsti_stat_wr", 32'(stat_wr_cnt), 32'd0);
        step();
        sample();
        check("rsti_discard", 32'(cmd_en), 32'd0);

        // Statistics after three writes
        do_write(30'h600);
        do_write(30'h700);
        do_write(30'h800);
        sample();
`ifdef ARB_STATS_EN
        check("stat_wr", 32'(stat_wr_cnt), 32'd3);
`else
        check("stat_wr", 32'(stat_wr_cnt), 32'd0);
`endif
        check("stat_rd", 32'(stat_rd_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
